// File: rtl/uart_tx_emitter.sv
// Transmit-only 8N1 UART with valid/ready byte intake and a registered serial line.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the serialiser.
module uart_tx_emitter #(
  parameter int unsigned clk_freq_hz = 12000000,
  parameter int unsigned baud_rate   = 9600,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_uart_tx
);

  localparam int unsigned BIT_CYCLES = clk_freq_hz / baud_rate;
  localparam int unsigned CW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned RELOAD_I   = BIT_CYCLES - 1;
  localparam logic [CW-1:0] CNT_RELOAD = RELOAD_I[CW-1:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  logic          start_frame;
  logic [7:0]    start_byte;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, push, pop;

  always_comb begin
    fifo_full   = (fifo_cnt == FULL_CNT);
    fifo_empty  = (fifo_cnt == '0);
    push        = i_valid && !fifo_full;
    start_frame = (state_q == IDLE) && !fifo_empty;
    pop         = start_frame;
    start_byte  = fifo_mem[rd_ptr];
    o_ready     = !fifo_full;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= i_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  localparam int unsigned unused_fifo_depth = FIFO_DEPTH;

  logic ready_q;

  always_comb begin
    start_frame = i_valid && ready_q;
    start_byte  = i_data;
    o_ready     = ready_q;
  end

  // Ready mirrors the next state so it drops with the start bit and rises after the stop bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) ready_q <= 1'b1;
    else       ready_q <= (state_d == IDLE);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start_frame) begin
          state_d = START;
          cnt_d   = CNT_RELOAD;
          bit_d   = '0;
          sh_d    = start_byte;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CNT_RELOAD;
          bit_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_emitter.sv
// Self-checking bench for uart_tx_emitter (BIT_CYCLES=4); frames are predicted from the 8N1 timing rules.
module tb_uart_tx_emitter;

  localparam int unsigned CLK_HZ = 16;
  localparam int unsigned BAUD   = 4;
  localparam int unsigned B      = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       tx;

  int checks   = 0;
  int failures = 0;

  uart_tx_emitter #(.clk_freq_hz(CLK_HZ), .baud_rate(BAUD), .FIFO_DEPTH(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (data),
    .i_valid  (valid),
    .o_ready  (ready),
    .o_uart_tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level in cycle k (1-based) after the accept edge of byte b.
  function automatic logic exp_line(input logic [7:0] b, input int unsigned k);
    int unsigned j;
    j = (k - 1) / B;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    return 1'b1;
  endfunction

  // Offers b, checks every cycle of its frame, and optionally pokes a byte while busy.
  task automatic send_frame(input logic [7:0] b, input int unsigned poke_at, input logic [7:0] poke_byte);
    logic [7:0]  rx;
    int unsigned j;
    rx = '0;
    check("ready_before_accept", ready, 1);
    data  = b;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    data  = 8'($urandom);
    for (int unsigned k = 1; k <= 10 * B; k++) begin
      if (k == poke_at) begin
        valid = 1'b1;
        data  = poke_byte;
      end else begin
        valid = 1'b0;
      end
      check("line_bit", tx, exp_line(b, k));
      check("ready_busy", ready, 0);
      j = (k - 1) / B;
      if (((k - 1) % B) == B / 2 && j >= 1 && j <= 8) rx[j-1] = tx;
      tick();
    end
    valid = 1'b0;
    check("ready_after_frame", ready, 1);
    check("line_after_frame", tx, 1);
    check("rx_byte", rx, b);
  endtask

  // Receiver: waits (bounded) for a start bit, then samples mid-bit.
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int unsigned budget;
    b = '0;
    ok = 1'b0;
    budget = 0;
    while (tx !== 1'b0 && budget < 30 * B) begin
      tick();
      budget++;
    end
    if (tx !== 1'b0) return;
    repeat (B / 2) tick();
    check("rx_start_mid", tx, 0);
    for (int unsigned i = 0; i < 8; i++) begin
      repeat (B) tick();
      b[i] = tx;
    end
    repeat (B) tick();
    check("rx_stop_mid", tx, 1);
    repeat (B - B / 2) tick();
    ok = 1'b1;
  endtask

  initial begin
    logic [7:0] rb;
    logic       ok;
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_tx", tx, 1);
    check("reset_ready", ready, 1);

`ifdef UART_TX_FIFO_EN
    for (int unsigned i = 0; i < 5; i++) begin
      check("fifo_ready_push", ready, 1);
      data  = 8'h31 + 8'(i);
      valid = 1'b1;
      tick();
    end
    data = 8'h36;
    check("fifo_full_ready", ready, 0);
    repeat (3) tick();
    valid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      rx_byte(rb, ok);
      check("fifo_rx_timeout", ok, 1);
      check("fifo_rx_byte", rb, 8'h31 + 8'(i));
    end
    for (int unsigned i = 0; i < 30; i++) begin
      check("fifo_line_idle", tx, 1);
      tick();
    end
    check("fifo_ready_empty", ready, 1);
`else
    send_frame(8'h55, 0, 8'h00);
    repeat (3) tick();
    send_frame(8'hA3, 0, 8'h00);
    repeat (2) tick();
    send_frame(8'h41, 10, 8'h42);
    repeat (1) tick();
    // back-to-back: second call accepts in the first ready cycle
    send_frame(8'h00, 0, 8'h00);
    send_frame(8'hFF, 0, 8'h00);
    send_frame(8'h5A, 10 * B, 8'hC3);
    for (int unsigned i = 0; i < 6; i++) begin
      logic [7:0] rnd;
      rnd = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      send_frame(rnd, (i % 2 == 1) ? $urandom_range(1, 10 * B) : 0, 8'($urandom));
    end

    data  = 8'h00;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (13) tick();
    check("midframe_low", tx, 0);
    check("midframe_busy", ready, 0);
    rst = 1'b1;
    tick();
    check("abort_tx", tx, 1);
    check("abort_ready", ready, 1);
    repeat (2) tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      check("post_reset_idle", tx, 1);
      tick();
    end
    check("post_reset_ready", ready, 1);
    send_frame(8'h96, 0, 8'h00);
    rx_byte(rb, ok);
    check("no_ghost_frame", ok, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
